// File: rtl/pc_ctrl_pkg.sv
// Shared opcodes, condition codes and flag bit positions for the fetch-side PC stage.
package pc_ctrl_pkg;

  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    NE     = 3'b000,
    EQ     = 3'b001,
    GT     = 3'b010,
    LT     = 3'b011,
    GTE    = 3'b100,
    LTE    = 3'b101,
    OVFL   = 3'b110,
    UNCOND = 3'b111
  } ccc_e;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  // Word offset of a B instruction: sign-extended imm9, scaled to bytes.
  function automatic logic signed [15:0] b_offset(input logic signed [8:0] imm9);
    return {{6{imm9[8]}}, imm9, 1'b0};
  endfunction

endpackage

// File: rtl/pc_control_branch_cond_eval.sv
// Combinational branch condition decode: (ccc, Z, V, N) -> condition true.
module branch_cond_eval
  import pc_ctrl_pkg::*;
(
  input  logic [2:0] i_ccc,
  input  logic       i_z,
  input  logic       i_v,
  input  logic       i_n,
  output logic       o_cond_true
);

  always_comb begin
    o_cond_true = 1'b0;
    case (ccc_e'(i_ccc))
      NE:      o_cond_true = ~i_z;
      EQ:      o_cond_true = i_z;
      GT:      o_cond_true = ~i_z & ~i_n;
      LT:      o_cond_true = i_n;
      GTE:     o_cond_true = i_z | (~i_z & ~i_n);
      LTE:     o_cond_true = i_n | i_z;
      OVFL:    o_cond_true = i_v;
      UNCOND:  o_cond_true = 1'b1;
      default: o_cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_control.sv
// Fetch-side PC stage: PC, {Z,V,N} flags, sticky halt and next-PC selection.
// Optional build macro PC_CONTROL_FLAG_BYPASS_EN lets branches see same-cycle flag writes.
module pc_control
  import pc_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        stall,
  input  logic [15:0] br_reg_data,
  input  logic [2:0]  flag_in,
  input  logic [2:0]  flag_en,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic [2:0]  flags,
  output logic        branch_taken,
  output logic        hlt
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  logic [15:0] r_pc;
  logic [2:0]  r_flags;
  logic [0:0]  r_state;

  logic [3:0]  w_op;
  logic [2:0]  w_ccc;
  logic [8:0]  w_imm9;
  logic        w_is_b;
  logic        w_is_br;
  logic        w_is_hlt;
  logic        w_halted;
  logic        w_advance;
  logic [2:0]  w_flags_eval;
  logic        w_cond_true;
  logic [15:0] w_pc_plus2;
  logic [15:0] w_b_target;
  logic [15:0] w_br_target;
  logic [15:0] w_next_pc;
  logic [2:0]  w_flags_next;
  logic        w_taken;

  assign w_op     = instr[15:12];
  assign w_ccc    = instr[11:9];
  assign w_imm9   = instr[8:0];
  assign w_is_b   = (w_op == OP_B);
  assign w_is_br  = (w_op == OP_BR);
  assign w_is_hlt = (w_op == HLT_OPCODE);

  assign w_halted  = (r_state == ST_HALTED);
  assign w_advance = ~stall & ~w_halted;

`ifdef PC_CONTROL_FLAG_BYPASS_EN
  // Compare-then-branch in one cycle: enabled flag bits come straight from the ALU.
  assign w_flags_eval = (flag_en & flag_in) | (~flag_en & r_flags);
`else
  assign w_flags_eval = r_flags;
`endif

  branch_cond_eval u_cond (
    .i_ccc       (w_ccc),
    .i_z         (w_flags_eval[FLAG_Z]),
    .i_v         (w_flags_eval[FLAG_V]),
    .i_n         (w_flags_eval[FLAG_N]),
    .o_cond_true (w_cond_true)
  );

  assign w_taken = ~w_halted & (w_is_b | w_is_br) & w_cond_true;

  // Target arithmetic wraps modulo 2^16; carries are discarded.
  assign w_pc_plus2  = r_pc + 16'd2;
  assign w_b_target  = w_pc_plus2 + 16'(b_offset(w_imm9));
  assign w_br_target = {br_reg_data[15:1], 1'b0};

  always_comb begin
    w_next_pc = w_pc_plus2;
    if (w_is_hlt) begin
      w_next_pc = r_pc;
    end else if (w_taken) begin
      w_next_pc = w_is_b ? w_b_target : w_br_target;
    end
  end

  always_comb begin
    w_flags_next = r_flags;
    for (int b = 0; b < 3; b++) begin
      if (flag_en[b]) begin
        w_flags_next[b] = flag_in[b];
      end
    end
  end

  // Register stage: everything freezes on stall or once halted; reset overrides both.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_flags <= 3'b000;
      r_state <= ST_RUN;
    end else if (w_advance) begin
      r_pc    <= w_next_pc;
      r_flags <= w_flags_next;
      if (w_is_hlt) begin
        r_state <= ST_HALTED;
      end
    end
  end

  assign pc           = r_pc;
  assign pc_plus2     = w_pc_plus2;
  assign flags        = r_flags;
  assign branch_taken = w_taken;
  assign hlt          = w_halted;

endmodule

// File: tb/tb_pc_control.sv
// Bench for pc_control: directed cases plus randomized traffic against a behavioural model.
module tb_pc_control;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic        stall;
  logic [15:0] br_reg_data;
  logic [2:0]  flag_in;
  logic [2:0]  flag_en;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic [2:0]  flags;
  logic        branch_taken;
  logic        hlt;

  pc_control dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .stall        (stall),
    .br_reg_data  (br_reg_data),
    .flag_in      (flag_in),
    .flag_en      (flag_en),
    .pc           (pc),
    .pc_plus2     (pc_plus2),
    .flags        (flags),
    .branch_taken (branch_taken),
    .hlt          (hlt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: Z,V,N kept as separate booleans, pc as plain 16-bit value.
  logic [15:0] m_pc;
  bit          m_z, m_v, m_n;
  bit          m_hlt;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_cond(input int ccc, input bit z, input bit v, input bit n);
    case (ccc)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || (!z && !n);
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic cycle(input bit r, input bit s, input logic [15:0] ins,
                       input logic [15:0] brd, input logic [2:0] fen, input logic [2:0] fin);
    int    op, ccc, imm;
    bit    ez, ev, en, taken;
    rst = r; stall = s; instr = ins; br_reg_data = brd; flag_en = fen; flag_in = fin;
    #1;
    op  = int'(ins[15:12]);
    ccc = int'(ins[11:9]);
    imm = int'(ins[8:0]);
    if (imm >= 256) imm = imm - 512;
    ez = m_z; ev = m_v; en = m_n;
`ifdef PC_CONTROL_FLAG_BYPASS_EN
    if (fen[2]) ez = fin[2];
    if (fen[1]) ev = fin[1];
    if (fen[0]) en = fin[0];
`endif
    taken = !m_hlt && (op == 12 || op == 13) && model_cond(ccc, ez, ev, en);
    if (!r) begin
      check("branch_taken", {15'd0, branch_taken}, {15'd0, taken});
      check("pc_plus2", pc_plus2, 16'(m_pc + 16'd2));
    end
    if (r) begin
      m_pc = 16'h0000; m_z = 0; m_v = 0; m_n = 0; m_hlt = 0;
    end else if (!s && !m_hlt) begin
      if (op == 15)          m_hlt = 1;
      else if (taken && op == 12) m_pc = 16'(int'(m_pc) + 2 + imm * 2);
      else if (taken)        m_pc = brd & 16'hFFFE;
      else                   m_pc = m_pc + 16'd2;
      if (fen[2]) m_z = fin[2];
      if (fen[1]) m_v = fin[1];
      if (fen[0]) m_n = fin[0];
    end
    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    check("flags", {13'd0, flags}, {13'd0, m_z, m_v, m_n});
    check("hlt", {15'd0, hlt}, {15'd0, m_hlt});
  endtask

  task automatic nop();
    cycle(0, 0, 16'h0000, 16'h0000, 3'b000, 3'b000);
  endtask

  // Unconditional BR to an address while loading all three flags.
  task automatic jump_set_flags(input logic [15:0] addr, input logic [2:0] f);
    cycle(0, 0, 16'hDE30, addr, 3'b111, f);
  endtask

  logic [15:0] exp_byp;

  initial begin
    m_pc = 16'h0000; m_z = 0; m_v = 0; m_n = 0; m_hlt = 0;

    cycle(1, 1, 16'hC1FF, 16'h0000, 3'b111, 3'b111);
    check("reset_pc", pc, 16'h0000);
    check("reset_flags", {13'd0, flags}, 16'h0000);
    check("reset_hlt", {15'd0, hlt}, 16'h0000);

    nop(); nop(); nop();
    check("seq_pc", pc, 16'h0006);

    jump_set_flags(16'h0010, 3'b100);
    cycle(0, 0, 16'hC205, 16'h0000, 3'b000, 3'b000);
    check("b_eq_taken", pc, 16'h001C);

    jump_set_flags(16'h0010, 3'b000);
    cycle(0, 0, 16'hC205, 16'h0000, 3'b000, 3'b000);
    check("b_eq_not_taken", pc, 16'h0012);

    jump_set_flags(16'h0010, 3'b000);
    cycle(0, 0, 16'hCFFF, 16'h0000, 3'b000, 3'b000);
    check("b_uncond_back", pc, 16'h0010);

    cycle(0, 0, 16'hDE30, 16'h1235, 3'b000, 3'b000);
    check("br_target", pc, 16'h1234);
    for (int i = 0; i < 3; i++) cycle(0, 1, 16'hDE30, 16'h4444, 3'b111, 3'b111);
    check("stall_hold", pc, 16'h1234);

    jump_set_flags(16'h0020, 3'b000);
    cycle(0, 0, 16'hC200, 16'h0000, 3'b100, 3'b100);
    check("bypass_imm0", pc, 16'h0022);

    jump_set_flags(16'h0020, 3'b000);
    cycle(0, 0, 16'hC202, 16'h0000, 3'b100, 3'b100);
`ifdef PC_CONTROL_FLAG_BYPASS_EN
    exp_byp = 16'h0026;
`else
    exp_byp = 16'h0022;
`endif
    check("bypass_imm2", pc, exp_byp);

    jump_set_flags(16'hFFFE, 3'b000);
    nop();
    check("pc_wrap", pc, 16'h0000);

    jump_set_flags(16'h0040, 3'b010);
    cycle(0, 1, 16'hF000, 16'h0000, 3'b000, 3'b000);
    check("hlt_stalled_ignored", {15'd0, hlt}, 16'h0000);
    cycle(0, 0, 16'hF000, 16'h0000, 3'b000, 3'b000);
    check("hlt_set", {15'd0, hlt}, 16'h0001);
    check("hlt_pc", pc, 16'h0040);
    cycle(0, 0, 16'hCE00, 16'h0000, 3'b111, 3'b101);
    cycle(0, 0, 16'hDE30, 16'h2222, 3'b111, 3'b101);
    check("halted_pc", pc, 16'h0040);
    check("halted_flags", {13'd0, flags}, 16'h0002);
    cycle(1, 0, 16'hCE00, 16'h0000, 3'b000, 3'b000);
    check("hlt_cleared", {15'd0, hlt}, 16'h0000);
    check("hlt_reset_pc", pc, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] ins;
      int          kind;
      kind = $urandom_range(0, 39);
      ins  = 16'($urandom);
      if (kind < 12)      ins[15:12] = 4'hC;
      else if (kind < 20) ins[15:12] = 4'hD;
      else if (kind == 20) ins[15:12] = 4'hF;
      else if (ins[15:12] == 4'hF) ins[15:12] = 4'h0;
      cycle($urandom_range(0, 29) == 0, $urandom_range(0, 4) == 0, ins,
            16'($urandom), 3'($urandom), 3'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
